lot_ticket_entry: RTL and testbench
===================================

// Module: lot_ticket_entry
// PURPOSE
// - Upstream feeder for the lottery block: collects one ticket of TICKET_LEN numbers from
//   keypad strobes, supports delete and confirm, range-checks every entry.
// - On confirm, streams the buffered ticket into the lottery block:
//   * insere high for TICKET_LEN consecutive cycles, one number per cycle.
//   * Then a 1-cycle fim pulse.
// - Single clock domain; sits between the keypad decoder and the lottery block.
// PARAMETERS
// - NUM_W       4  width of one lottery number
// - TICKET_LEN  5  numbers per ticket (2..7)
// - MAX_VAL     9  largest legal number; entries > MAX_VAL are rejected
// PORTS
// - clk        in   1           system clock, rising edge
// - reset      in   1           asynchronous, active-low reset
// - key_valid  in   1           1-cycle strobe: key_val holds a new number
// - key_val    in   NUM_W       number entered, index 0 = MSB ([0:NUM_W-1])
// - key_del    in   1           1-cycle strobe: drop last entered number
// - key_ok     in   1           1-cycle strobe: confirm ticket
// - count      out  3           numbers currently buffered (0..TICKET_LEN)
// - busy       out  1           1 while streaming/fim; keypad inputs ignored
// - err        out  1           1-cycle pulse: last strobe rejected
// - insere     out  1           to lottery block: num valid this cycle
// - num        out  NUM_W       to lottery block, index 0 = MSB ([0:NUM_W-1])
// - fim        out  1           to lottery block: 1-cycle end-of-ticket pulse
// BEHAVIOUR
// - Reset (reset=0, async): state=S_ENTRY, count=0, busy=0, err=0, insere=0, num=0, fim=0.
//   Buffer contents are don't-care.
// - All outputs are registered.
// - FSM states: S_ENTRY -> S_SEND -> S_FIM -> S_ENTRY.
// - S_ENTRY: act on one strobe per cycle, priority key_del > key_valid > key_ok.
//   Lower-priority strobes in the same cycle are dropped silently (no err).
//   * key_del: count>0 -> count-1. count==0 -> no change, err.
//   * key_valid: count==TICKET_LEN -> ignored, err. key_val>MAX_VAL -> ignored, err.
//     Otherwise buf[count]=key_val, count+1.
//   * key_ok: count<TICKET_LEN -> err, stay in S_ENTRY.
//     count==TICKET_LEN -> go to S_SEND, busy=1 from next cycle.
// - S_SEND: index i=0..TICKET_LEN-1, one per cycle; insere=1, num=buf[i].
//   Accepted key_ok at edge N -> insere=1 in cycles N+1..N+TICKET_LEN.
// - S_FIM: cycle N+TICKET_LEN+1: insere=0, num=0, fim=1.
// - Back in S_ENTRY at N+TICKET_LEN+2: fim=0, busy=0, count=0.
// - busy=1 exactly in cycles N+1..N+TICKET_LEN+1. All key_* strobes are ignored then:
//   no err, no buffer change.
// - err is asserted the cycle after the offending edge, for one cycle.
// - insere and fim are never high together; num=0 whenever insere=0.
// - Reset during S_SEND/S_FIM aborts immediately: no fim is issued and the ticket is lost.
// - count arithmetic saturates at 0 and TICKET_LEN and never wraps.
// CONFIGURATION
// - LOT_ENTRY_NODUP_EN defined:
//   * key_valid whose key_val equals any buf[0..count-1] is rejected with err.
//   * Compare covers only occupied slots.
// - LOT_ENTRY_NODUP_EN undefined: duplicates accepted (e.g. 0,0 legal in one ticket).
// - The macro changes nothing else.
// TESTING
// - Reset then enter 4,7,0,1,9, key_ok.
//   -> count=5; insere high 5 cycles with num=4,7,0,1,9; fim=1 next cycle; count=0 after.
// - key_valid with key_val=12 (MAX_VAL=9) -> err pulse 1 cycle, count unchanged.
// - Enter 8,9,0,2 then key_ok -> err, no insere.
//   Then key_del -> count=3; enter 2,0, key_ok -> stream 8,9,0,2,0.
// - Buffer full (5) plus key_valid=3 -> err, buffer kept.
//   key_del+key_valid in same cycle -> count 4, no err.
// - During S_SEND assert key_valid/key_ok -> ignored, err=0.
//   Drop reset at 3rd insere -> all outputs 0 at once, no fim, count=0.
// - NODUP_EN defined: enter 0,0 -> second 0 gives err, count=1.
//   Undefined: count=2, no err.

Source files
------------

// File: rtl/lot_ticket_entry.sv
// Keypad ticket collector feeding the lottery block (insere/num stream, then fim).
// Optional LOT_ENTRY_NODUP_EN: reject entries already present in the ticket.
module lot_ticket_entry #(
    parameter int NUM_W      = 4,
    parameter int TICKET_LEN = 5,
    parameter int MAX_VAL    = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [0:NUM_W-1] key_val,
    input  logic             key_del,
    input  logic             key_ok,
    output logic [2:0]       count,
    output logic             busy,
    output logic             err,
    output logic             insere,
    output logic [0:NUM_W-1] num,
    output logic             fim
);

    typedef enum logic [1:0] {
        S_ENTRY,
        S_SEND,
        S_FIM
    } state_t;

    localparam logic [2:0]       LEN  = 3'(TICKET_LEN);
    localparam logic [0:NUM_W-1] MAXV = NUM_W'(MAX_VAL);

    state_t           state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [2:0]       idx_q, idx_d;
    logic [0:NUM_W-1] buf_q [8];
    logic [0:NUM_W-1] buf_d [8];
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             insere_q, insere_d;
    logic [0:NUM_W-1] num_q, num_d;
    logic             fim_q, fim_d;
    logic             dup;

`ifdef LOT_ENTRY_NODUP_EN
    always_comb begin
        dup = 1'b0;
        for (int j = 0; j < TICKET_LEN; j++) begin
            if (3'(j) < count_q && buf_q[j] == key_val) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        busy_d   = 1'b0;
        err_d    = 1'b0;
        insere_d = 1'b0;
        num_d    = '0;
        fim_d    = 1'b0;
        unique case (state_q)
            S_ENTRY: begin
                if (key_del) begin
                    if (count_q != 3'd0) begin
                        count_d = count_q - 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (key_valid) begin
                    if (count_q == LEN || key_val > MAXV || dup) begin
                        err_d = 1'b1;
                    end else begin
                        buf_d[count_q] = key_val;
                        count_d        = count_q + 3'd1;
                    end
                end else if (key_ok) begin
                    if (count_q != LEN) begin
                        err_d = 1'b1;
                    end else begin
                        // first number goes out on the cycle right after confirm
                        state_d  = S_SEND;
                        busy_d   = 1'b1;
                        insere_d = 1'b1;
                        num_d    = buf_q[0];
                        idx_d    = 3'd1;
                    end
                end
            end
            S_SEND: begin
                busy_d = 1'b1;
                if (idx_q == LEN) begin
                    state_d = S_FIM;
                    fim_d   = 1'b1;
                end else begin
                    insere_d = 1'b1;
                    num_d    = buf_q[idx_q];
                    idx_d    = idx_q + 3'd1;
                end
            end
            S_FIM: begin
                state_d = S_ENTRY;
                count_d = 3'd0;
            end
            default: begin
                state_d = S_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_ENTRY;
            count_q  <= 3'd0;
            idx_q    <= 3'd0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            insere_q <= 1'b0;
            num_q    <= '0;
            fim_q    <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            insere_q <= insere_d;
            num_q    <= num_d;
            fim_q    <= fim_d;
            buf_q    <= buf_d;
        end
    end

    assign count  = count_q;
    assign busy   = busy_q;
    assign err    = err_q;
    assign insere = insere_q;
    assign num    = num_q;
    assign fim    = fim_q;

endmodule

// File: tb/tb_lot_ticket_entry.sv
// Bench for lot_ticket_entry: directed scenarios plus random strobes,
// all checked against a queue-based ticket model.
module tb_lot_ticket_entry;

    localparam int TL   = 5;
    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [0:3] key_val;
    logic       key_del;
    logic       key_ok;
    logic [2:0] count;
    logic       busy;
    logic       err;
    logic       insere;
    logic [0:3] num;
    logic       fim;

    int n_tests = 0;
    int n_fail  = 0;
    int q[$];
    int phase   = 0;
    int e_err   = 0;
    bit nodup   = 1'b0;

    lot_ticket_entry #(
        .NUM_W(4),
        .TICKET_LEN(TL),
        .MAX_VAL(MAXV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_val(key_val),
        .key_del(key_del),
        .key_ok(key_ok),
        .count(count),
        .busy(busy),
        .err(err),
        .insere(insere),
        .num(num),
        .fim(fim)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_ticket(input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // phase 0 = collecting; 1..TL = streaming q[phase-1]; TL+1 = fim
    task automatic model_edge(input bit d, input bit v, input int val,
                              input bit o);
        e_err = 0;
        if (phase > 0) begin
            phase++;
            if (phase == TL + 2) begin
                phase = 0;
                q.delete();
            end
        end else if (d) begin
            if (q.size() > 0) void'(q.pop_back());
            else e_err = 1;
        end else if (v) begin
            if (q.size() == TL || val > MAXV || (nodup && in_ticket(val)))
                e_err = 1;
            else
                q.push_back(val);
        end else if (o) begin
            if (q.size() < TL) e_err = 1;
            else phase = 1;
        end
    endtask

    task automatic check_outs;
        bit ins;
        ins = (phase >= 1 && phase <= TL);
        chk("count", 32'(count), 32'(q.size()));
        chk("busy", 32'(busy), 32'(phase >= 1 && phase <= TL + 1));
        chk("err", 32'(err), 32'(e_err));
        chk("insere", 32'(insere), 32'(ins));
        chk("num", 32'(num), ins ? 32'(q[phase-1]) : 32'd0);
        chk("fim", 32'(fim), 32'(phase == TL + 1));
    endtask

    task automatic step(input bit d, input bit v, input int val,
                        input bit o);
        key_del   = d;
        key_valid = v;
        key_val   = 4'(val);
        key_ok    = o;
        @(posedge clk);
        model_edge(d, v, val, o);
        #1;
        check_outs();
        key_del   = 1'b0;
        key_valid = 1'b0;
        key_ok    = 1'b0;
    endtask

    task automatic enter(input int val);
        step(1'b0, 1'b1, val, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset;
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        phase = 0;
        e_err = 0;
        check_outs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
`ifdef LOT_ENTRY_NODUP_EN
        nodup = 1'b1;
`endif
        key_del   = 1'b0;
        key_valid = 1'b0;
        key_val   = '0;
        key_ok    = 1'b0;
        reset     = 1'b0;
        #2;
        check_outs();
        @(negedge clk);
        reset = 1'b1;

        enter(4); enter(7); enter(0); enter(1); enter(9);
        step(1'b0, 1'b0, 0, 1'b1);
        idle(TL + 2);

        enter(12);

        enter(8); enter(9); enter(0); enter(2);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 0, 1'b0);
        enter(2); enter(0);
        step(1'b0, 1'b0, 0, 1'b1);
        idle(TL + 2);

        enter(1); enter(2); enter(3); enter(5); enter(6);
        enter(3);
        step(1'b1, 1'b1, 3, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 7, 1'b1);
        enter(3); enter(4);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b1, 3, 1'b1);
        step(1'b1, 1'b1, 5, 1'b0);
        do_reset();

        enter(0); enter(0);
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 60,
                 int'($urandom_range(0, 11)), $urandom_range(0, 99) < 20);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
